multi_share_read_master: RTL and testbench
==========================================

MULTI_SHARE_READ_MASTER -- requirements
Module: multi_share_read_master

Interface
REQ-001 SHALL have parameter DATA_W, default 512: Avalon data and line width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 64: Avalon address width.
REQ-003 SHALL have parameter HCNT_W, default 9: feature-line count width.
REQ-004 SHALL have parameter WCNT_W, default 4: weight-line count width.
REQ-005 SHALL have parameter ADDR_STEP, default 1: address increment per line.
REQ-006 SHALL have ports:
- clk  in  1  single clock; rising edge.
- rst  in  1  synchronous, active-high reset.
- Start_i  in  1  start pulse.
- Mode_i  in  2  transfer mode: 00 weights only; 01 weights then features; 10 features only; 11 treated as 01.
- Height_i  in  HCNT_W  number of feature lines.
- WgtLines_i  in  WCNT_W  number of weight lines.
- DataBase_i  in  ADDR_W  feature base address.
- WgtBase_i  in  ADDR_W  weight base address.
- Halt_i  in  1  downstream stall request.
- AvalonAddr_o  out  ADDR_W  read address.
- AvalonRead_o  out  1  read request.
- AvalonByteEnable_o  out  DATA_W/8  byte enables, all ones.
- AvalonLock_o  out  1  bus lock.
- AvalonReadData_i  in  DATA_W  read data.
- AvalonWaitReq_i  in  1  waitrequest.
- IBValid_o, IBFirst_o, IBLast_o  out  1 each  feature-line strobes.
- IBLine_o  out  DATA_W  feature line.
- WBValid_o, WBFirst_o, WBLast_o  out  1 each  weight-line strobes.
- WBLine_o  out  DATA_W  weight line.
- Busy_o  out  1  transfer in progress.
- Done_o  out  1  one-cycle completion pulse.

Function
REQ-007 SHALL implement FSM states IDLE, WGT, FEAT and FLUSH.
REQ-008 Start_i in IDLE SHALL latch Mode_i, Height_i, WgtLines_i, DataBase_i and WgtBase_i, then enter WGT (modes 00/01/11 with WgtLines_i≠0), else FEAT (Height_i≠0 and mode≠00), else FLUSH. Start_i outside IDLE SHALL be ignored.
REQ-009 A read SHALL be accepted on a cycle with AvalonRead_o=1 and AvalonWaitReq_i=0. Each acceptance SHALL increment the active phase index.
REQ-010 AvalonAddr_o SHALL be base + index×ADDR_STEP, computed modulo 2^ADDR_W. Base SHALL be WgtBase in WGT and DataBase in FEAT.
REQ-011 After the last weight acceptance, the FSM SHALL go to FEAT (mode 01/11 with Height≠0) or to FLUSH. After the last feature acceptance it SHALL go to FLUSH. FLUSH SHALL return to IDLE after one cycle.
REQ-012 AvalonRead_o SHALL be 1 in WGT/FEAT unless Halt_i=1. Exception: a read presented in the previous cycle with AvalonWaitReq_i=1 SHALL be held regardless of Halt_i. Address SHALL stay stable while held.
REQ-013 Read data SHALL be valid exactly one cycle after acceptance. IBValid_o/WBValid_o SHALL be registered acceptance flags tagged by phase. Lines SHALL be passed through from AvalonReadData_i.
REQ-014 First and Last strobes SHALL coincide with the Valid of index 0 and of index count-1. A single-line phase SHALL assert both.
REQ-015 AvalonLock_o SHALL be 1 exactly while the state is FEAT.
REQ-016 Busy_o SHALL be 1 in every state except IDLE.
REQ-017 Done_o SHALL pulse in the FLUSH cycle, coincident with the final Valid when any lines were read.
REQ-018 Zero-length configuration: Start_i → FLUSH, then Done_o at cycle N+1 with no reads issued.

Reset
REQ-019 While rst=1 the FSM SHALL go to IDLE and counters to 0. All outputs SHALL be 0, except AvalonByteEnable_o (all ones) and the data lines.
REQ-020 Reset mid-transfer SHALL drop outstanding reads: no Valid, First, Last or Done after rst deasserts.

Structure
REQ-021 A shared package SHALL hold the FSM state enum and the mode encodings.
REQ-022 A single sub-module, line_addr_gen, SHALL implement the counter-plus-address generator and SHALL be instantiated once per phase.

Verification
REQ-023 Mode 01, WgtLines=2, Height=3, WgtBase=0x100, DataBase=0x200, no wait → addresses 0x100, 0x101, 0x200, 0x201, 0x202 on consecutive cycles. WBFirst on line 0, WBLast on line 1, IBFirst/IBLast on lines 0/2. Done with IBLast.
REQ-024 Mode 10, Height=4, AvalonWaitReq_i high 3 cycles on the second read → address 0x201 held 4 cycles, exactly 4 IBValid, Lock high only in FEAT.
REQ-025 Halt_i asserted while a read is in waitrequest → read held until accepted, then deasserted until Halt_i falls. No lines lost or duplicated.
REQ-026 Mode 00, WgtLines=0 → no AvalonRead_o, Done_o at Start+1 cycle, Busy_o for one cycle.
REQ-027 rst asserted after the second feature acceptance, Height=5 → all strobes 0 next cycle. A new Start then restarts from DataBase.
REQ-028 DataBase=2^ADDR_W−1, Height=2 → addresses wrap to all-ones then 0.

Source files
------------

// File: rtl/multi_share_read_master_pkg.sv
// Shared FSM state and transfer-mode encodings for the weight/feature read master.
// No logic of its own; the helpers decode which phases a mode enables.
// Mode 11 behaves like mode 01 (weights, then features).
package multi_share_read_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WGT   = 2'd1,
      ST_FEAT  = 2'd2,
      ST_FLUSH = 2'd3
   } state_e;

   localparam logic [1:0] MODE_WGT          = 2'b00;
   localparam logic [1:0] MODE_WGT_FEAT     = 2'b01;
   localparam logic [1:0] MODE_FEAT         = 2'b10;
   localparam logic [1:0] MODE_WGT_FEAT_ALT = 2'b11;

   // Every mode except features-only carries a weight phase
   function automatic logic mode_has_wgt(input logic [1:0] m);
      return m != MODE_FEAT;
   endfunction

   // Every mode except weights-only carries a feature phase
   function automatic logic mode_has_feat(input logic [1:0] m);
      return m != MODE_WGT;
   endfunction

endpackage

// File: rtl/line_addr_gen.sv
// Per-phase line counter and address generator: addr = base + idx*ADDR_STEP.
// Latency: address and first/last flags are combinational from registered state.
// Backpressure: the index advances only on inc_i (an accepted read), so it holds under waitrequest.
module line_addr_gen
   import multi_share_read_master_pkg::*;
#(
   parameter int ADDR_W    = 64,
   parameter int CNT_W     = 9,
   parameter int ADDR_STEP = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              inc_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [CNT_W-1:0]  count_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              first_o,
   output logic              last_o
);

   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  idx_q;

   // Latch base/count at start, then step the index once per accepted read
   always_ff @(posedge clk) begin
      if (rst) begin
         base_q <= '0;
         cnt_q  <= '0;
         idx_q  <= '0;
      end else if (load_i) begin
         base_q <= base_i;
         cnt_q  <= count_i;
         idx_q  <= '0;
      end else if (inc_i) begin
         idx_q  <= idx_q + CNT_W'(1);
      end
   end

   assign addr_o  = base_q + (ADDR_W'(idx_q) * ADDR_W'(ADDR_STEP));
   assign first_o = (idx_q == '0);
   assign last_o  = (idx_q == (cnt_q - CNT_W'(1)));

endmodule

// File: rtl/multi_share_read_master.sv
// Avalon read master streaming a weight phase and/or a feature phase into line buffers.
// Latency: a line's Valid/First/Last appear one cycle after its read is accepted.
// Backpressure: Halt_i suppresses new reads; a read stalled by waitrequest is held until accepted.
module multi_share_read_master
   import multi_share_read_master_pkg::*;
#(
   parameter int DATA_W    = 512,
   parameter int ADDR_W    = 64,
   parameter int HCNT_W    = 9,
   parameter int WCNT_W    = 4,
   parameter int ADDR_STEP = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                Start_i,
   input  logic [1:0]          Mode_i,
   input  logic [HCNT_W-1:0]   Height_i,
   input  logic [WCNT_W-1:0]   WgtLines_i,
   input  logic [ADDR_W-1:0]   DataBase_i,
   input  logic [ADDR_W-1:0]   WgtBase_i,
   input  logic                Halt_i,
   output logic [ADDR_W-1:0]   AvalonAddr_o,
   output logic                AvalonRead_o,
   output logic [DATA_W/8-1:0] AvalonByteEnable_o,
   output logic                AvalonLock_o,
   input  logic [DATA_W-1:0]   AvalonReadData_i,
   input  logic                AvalonWaitReq_i,
   output logic                IBValid_o,
   output logic                IBFirst_o,
   output logic                IBLast_o,
   output logic [DATA_W-1:0]   IBLine_o,
   output logic                WBValid_o,
   output logic                WBFirst_o,
   output logic                WBLast_o,
   output logic [DATA_W-1:0]   WBLine_o,
   output logic                Busy_o,
   output logic                Done_o
);

   state_e state_q;
   logic   feat_go_q;
   logic   held_q;
   logic   ib_vld_q, ib_first_q, ib_last_q;
   logic   wb_vld_q, wb_first_q, wb_last_q;

   logic              start_acc, wgt_en, feat_en, in_xfer, rd, acc, w_inc, f_inc;
   logic [ADDR_W-1:0] w_addr, f_addr;
   logic              w_first, w_last, f_first, f_last;

   assign start_acc = (state_q == ST_IDLE) && Start_i;
   assign wgt_en    = mode_has_wgt(Mode_i) && (WgtLines_i != '0);
   assign feat_en   = mode_has_feat(Mode_i) && (Height_i != '0);
   assign in_xfer   = (state_q == ST_WGT) || (state_q == ST_FEAT);
   // A read stalled last cycle stays on the bus even if Halt_i rises meanwhile
   assign rd        = !rst && in_xfer && (!Halt_i || held_q);
   assign acc       = rd && !AvalonWaitReq_i;
   assign w_inc     = acc && (state_q == ST_WGT);
   assign f_inc     = acc && (state_q == ST_FEAT);

   line_addr_gen #(.ADDR_W(ADDR_W), .CNT_W(WCNT_W), .ADDR_STEP(ADDR_STEP)) u_wgt_gen (
      .clk(clk), .rst(rst), .load_i(start_acc), .inc_i(w_inc),
      .base_i(WgtBase_i), .count_i(WgtLines_i),
      .addr_o(w_addr), .first_o(w_first), .last_o(w_last)
   );

   line_addr_gen #(.ADDR_W(ADDR_W), .CNT_W(HCNT_W), .ADDR_STEP(ADDR_STEP)) u_feat_gen (
      .clk(clk), .rst(rst), .load_i(start_acc), .inc_i(f_inc),
      .base_i(DataBase_i), .count_i(Height_i),
      .addr_o(f_addr), .first_o(f_first), .last_o(f_last)
   );

   // Phase sequencing, waitrequest hold flag and registered line strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         feat_go_q  <= 1'b0;
         held_q     <= 1'b0;
         ib_vld_q   <= 1'b0;
         ib_first_q <= 1'b0;
         ib_last_q  <= 1'b0;
         wb_vld_q   <= 1'b0;
         wb_first_q <= 1'b0;
         wb_last_q  <= 1'b0;
      end else begin
         held_q     <= rd && AvalonWaitReq_i;
         wb_vld_q   <= w_inc;
         wb_first_q <= w_inc && w_first;
         wb_last_q  <= w_inc && w_last;
         ib_vld_q   <= f_inc;
         ib_first_q <= f_inc && f_first;
         ib_last_q  <= f_inc && f_last;
         case (state_q)
            ST_IDLE: begin
               if (Start_i) begin
                  feat_go_q <= feat_en;
                  if (wgt_en)       state_q <= ST_WGT;
                  else if (feat_en) state_q <= ST_FEAT;
                  else              state_q <= ST_FLUSH;
               end
            end
            ST_WGT: begin
               if (w_inc && w_last) state_q <= feat_go_q ? ST_FEAT : ST_FLUSH;
            end
            ST_FEAT: begin
               if (f_inc && f_last) state_q <= ST_FLUSH;
            end
            ST_FLUSH: state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   assign AvalonRead_o       = rd;
   assign AvalonAddr_o       = rst                   ? '0     :
                               (state_q == ST_WGT)   ? w_addr :
                               (state_q == ST_FEAT)  ? f_addr : '0;
   assign AvalonByteEnable_o = '1;
   assign AvalonLock_o       = !rst && (state_q == ST_FEAT);
   assign Busy_o             = !rst && (state_q != ST_IDLE);
   assign Done_o             = !rst && (state_q == ST_FLUSH);
   assign IBValid_o          = !rst && ib_vld_q;
   assign IBFirst_o          = !rst && ib_first_q;
   assign IBLast_o           = !rst && ib_last_q;
   assign WBValid_o          = !rst && wb_vld_q;
   assign WBFirst_o          = !rst && wb_first_q;
   assign WBLast_o           = !rst && wb_last_q;
   assign IBLine_o           = AvalonReadData_i;
   assign WBLine_o           = AvalonReadData_i;

endmodule

// File: tb/tb_multi_share_read_master.sv
// Bench for multi_share_read_master: vector table plus randomized transfers against a
// queue-based model of the expected read sequence, and directed reset/wrap sequences.
module tb_multi_share_read_master;
   localparam int DATA_W = 512;
   localparam int ADDR_W = 64;
   localparam int HCNT_W = 9;
   localparam int WCNT_W = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                Start_i;
   logic [1:0]          Mode_i;
   logic [HCNT_W-1:0]   Height_i;
   logic [WCNT_W-1:0]   WgtLines_i;
   logic [ADDR_W-1:0]   DataBase_i;
   logic [ADDR_W-1:0]   WgtBase_i;
   logic                Halt_i;
   logic [ADDR_W-1:0]   AvalonAddr_o;
   logic                AvalonRead_o;
   logic [DATA_W/8-1:0] AvalonByteEnable_o;
   logic                AvalonLock_o;
   logic [DATA_W-1:0]   AvalonReadData_i;
   logic                AvalonWaitReq_i;
   logic                IBValid_o, IBFirst_o, IBLast_o;
   logic [DATA_W-1:0]   IBLine_o;
   logic                WBValid_o, WBFirst_o, WBLast_o;
   logic [DATA_W-1:0]   WBLine_o;
   logic                Busy_o, Done_o;

   always #5 clk = ~clk;

   multi_share_read_master dut (
      .clk(clk), .rst(rst), .Start_i(Start_i), .Mode_i(Mode_i), .Height_i(Height_i),
      .WgtLines_i(WgtLines_i), .DataBase_i(DataBase_i), .WgtBase_i(WgtBase_i),
      .Halt_i(Halt_i), .AvalonAddr_o(AvalonAddr_o), .AvalonRead_o(AvalonRead_o),
      .AvalonByteEnable_o(AvalonByteEnable_o), .AvalonLock_o(AvalonLock_o),
      .AvalonReadData_i(AvalonReadData_i), .AvalonWaitReq_i(AvalonWaitReq_i),
      .IBValid_o(IBValid_o), .IBFirst_o(IBFirst_o), .IBLast_o(IBLast_o), .IBLine_o(IBLine_o),
      .WBValid_o(WBValid_o), .WBFirst_o(WBFirst_o), .WBLast_o(WBLast_o), .WBLine_o(WBLine_o),
      .Busy_o(Busy_o), .Done_o(Done_o)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      bit                feat;
      bit                first;
      bit                last;
   } rd_t;

   typedef struct {
      logic [1:0]  mode;
      int          height;
      int          wgt;
      logic [63:0] dbase;
      logic [63:0] wbase;
      int          wait_pct;
      int          halt_pct;
      int          wait_idx;
      int          wait_len;
      int          exp_nwb;
      int          exp_nib;
      int          exp_reads;
   } vec_t;

   logic [ADDR_W-1:0] acc_log[$];
   int n_wb, n_ib, n_reads;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
      return {8{a ^ 64'hC3A5_5A3C_0F0F_F0F0}};
   endfunction

   // One complete transfer: start pulse, then cycle-by-cycle comparison with the model
   task automatic run_xfer(input vec_t c);
      rd_t  q[$];
      rd_t  pend_rd;
      bit   pend, held, done_seen, exp_read, exp_done;
      int   k, wc;
      q.delete();
      acc_log.delete();
      n_wb = 0; n_ib = 0; n_reads = 0;
      if (c.mode != 2'b10)
         for (int i = 0; i < c.wgt; i++)
            q.push_back('{addr: c.wbase + ADDR_W'(i), feat: 1'b0, first: (i == 0), last: (i == c.wgt - 1)});
      if (c.mode != 2'b00)
         for (int i = 0; i < c.height; i++)
            q.push_back('{addr: c.dbase + ADDR_W'(i), feat: 1'b1, first: (i == 0), last: (i == c.height - 1)});

      Mode_i = c.mode; Height_i = HCNT_W'(c.height); WgtLines_i = WCNT_W'(c.wgt);
      DataBase_i = c.dbase; WgtBase_i = c.wbase; Halt_i = 1'b0; AvalonWaitReq_i = 1'b0;
      Start_i = 1'b1;
      @(posedge clk); #1;
      Start_i = 1'b0;

      pend = 0; held = 0; done_seen = 0; k = 0; wc = 0;
      pend_rd = '{addr: '0, feat: 1'b0, first: 1'b0, last: 1'b0};
      for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
         Halt_i   = (int'($urandom_range(99)) < c.halt_pct);
         exp_read = (q.size() != 0) && (!Halt_i || held);
         if (k == c.wait_idx && wc < c.wait_len) begin
            AvalonWaitReq_i = 1'b1;
            if (exp_read) wc++;
         end else begin
            AvalonWaitReq_i = (int'($urandom_range(99)) < c.wait_pct);
         end
         AvalonReadData_i = pend ? data_of(pend_rd.addr) : {16{$urandom}};
         // Start and configuration noise while busy must be ignored
         Start_i    = ($urandom_range(7) == 0);
         Mode_i     = 2'($urandom);
         Height_i   = HCNT_W'($urandom);
         WgtLines_i = WCNT_W'($urandom);
         #1;
         chk("read", AvalonRead_o, exp_read);
         if (exp_read) chk("addr", AvalonAddr_o, q[0].addr);
         chk("lock", AvalonLock_o, (q.size() != 0) && q[0].feat);
         chk("busy", Busy_o, 1);
         chk("wb_vld", WBValid_o, pend && !pend_rd.feat);
         chk("ib_vld", IBValid_o, pend && pend_rd.feat);
         if (pend && !pend_rd.feat) begin
            chk("wb_first", WBFirst_o, pend_rd.first);
            chk("wb_last", WBLast_o, pend_rd.last);
            chk("wb_line", WBLine_o == data_of(pend_rd.addr), 1);
         end
         if (pend && pend_rd.feat) begin
            chk("ib_first", IBFirst_o, pend_rd.first);
            chk("ib_last", IBLast_o, pend_rd.last);
            chk("ib_line", IBLine_o == data_of(pend_rd.addr), 1);
         end
         exp_done = (q.size() == 0);
         chk("done", Done_o, exp_done);
         if (WBValid_o) n_wb++;
         if (IBValid_o) n_ib++;
         if (AvalonRead_o) n_reads++;
         pend = 0;
         if (exp_read && !AvalonWaitReq_i) begin
            pend    = 1;
            pend_rd = q.pop_front();
            acc_log.push_back(pend_rd.addr);
            k++;
         end
         held = exp_read && AvalonWaitReq_i;
         if (exp_done) done_seen = 1;
         @(posedge clk); #1;
      end
      chk("done_seen", done_seen, 1);
      Start_i = 1'b0; Halt_i = 1'b0; AvalonWaitReq_i = 1'b0;
      #1;
      chk("idle_busy", Busy_o, 0);
      chk("idle_done", Done_o, 0);
      chk("idle_vld", IBValid_o | WBValid_o, 0);
      chk("idle_read", AvalonRead_o, 0);
   endtask

   task automatic chk_all_quiet(input string nm);
      chk({nm, "_read"}, AvalonRead_o, 0);
      chk({nm, "_strobes"}, {IBValid_o, IBFirst_o, IBLast_o, WBValid_o, WBFirst_o, WBLast_o}, 0);
      chk({nm, "_done"}, Done_o, 0);
      chk({nm, "_busy"}, Busy_o, 0);
      chk({nm, "_lock"}, AvalonLock_o, 0);
   endtask

   vec_t vecs[9];
   vec_t rv;
   logic [ADDR_W-1:0] exp_addrs[$];
   logic [ADDR_W-1:0] all_ones;

   initial begin
      all_ones = '1;
      vecs[0] = '{2'b01, 3, 2, 64'h200, 64'h100, 0, 0, -1, 0, 2, 3, 5};
      vecs[1] = '{2'b10, 4, 0, 64'h200, 64'h100, 0, 0, 1, 3, 0, 4, 7};
      vecs[2] = '{2'b00, 5, 0, 64'h200, 64'h100, 0, 0, -1, 0, 0, 0, 0};
      vecs[3] = '{2'b10, 2, 3, all_ones, 64'h100, 0, 0, -1, 0, 0, 2, 2};
      vecs[4] = '{2'b11, 1, 1, 64'h40, 64'h80, 0, 0, -1, 0, 1, 1, 2};
      vecs[5] = '{2'b00, 3, 3, 64'h40, 64'h80, 0, 0, -1, 0, 3, 0, 3};
      vecs[6] = '{2'b01, 0, 2, 64'h40, 64'h80, 0, 0, -1, 0, 2, 0, 2};
      vecs[7] = '{2'b10, 3, 0, 64'h900, 64'h80, 50, 50, -1, 0, 0, 3, -1};
      vecs[8] = '{2'b01, 2, 2, 64'h900, 64'h700, 40, 40, 0, 2, 2, 2, -1};

      rst = 1'b1; Start_i = 1'b0; Mode_i = '0; Height_i = '0; WgtLines_i = '0;
      DataBase_i = '0; WgtBase_i = '0; Halt_i = 1'b0; AvalonWaitReq_i = 1'b0;
      AvalonReadData_i = '0;
      @(posedge clk); #1;
      chk_all_quiet("reset");
      chk("reset_addr", AvalonAddr_o, 0);
      chk("reset_be", &AvalonByteEnable_o, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk_all_quiet("post_reset");

      for (int i = 0; i < 9; i++) begin
         run_xfer(vecs[i]);
         chk($sformatf("v%0d_nwb", i), n_wb, vecs[i].exp_nwb);
         chk($sformatf("v%0d_nib", i), n_ib, vecs[i].exp_nib);
         if (vecs[i].exp_reads >= 0) chk($sformatf("v%0d_reads", i), n_reads, vecs[i].exp_reads);
         if (i == 0) begin
            exp_addrs = '{64'h100, 64'h101, 64'h200, 64'h201, 64'h202};
            chk("v0_len", acc_log.size(), 5);
            for (int j = 0; j < 5 && j < acc_log.size(); j++) chk("v0_seq", acc_log[j], exp_addrs[j]);
         end
         if (i == 3) begin
            chk("wrap_len", acc_log.size(), 2);
            if (acc_log.size() == 2) begin
               chk("wrap_a0", acc_log[0], all_ones);
               chk("wrap_a1", acc_log[1], 0);
            end
         end
      end

      // Reset in the middle of a feature phase
      Mode_i = 2'b10; Height_i = 9'd5; WgtLines_i = '0; DataBase_i = 64'h300; WgtBase_i = 64'h0;
      Start_i = 1'b1;
      @(posedge clk); #1;
      Start_i = 1'b0;
      #1;
      chk("mid_a0", AvalonAddr_o, 64'h300);
      chk("mid_r0", AvalonRead_o, 1);
      @(posedge clk); #1;
      chk("mid_a1", AvalonAddr_o, 64'h301);
      chk("mid_v0", IBValid_o & IBFirst_o, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk_all_quiet("mid_rst");
      @(posedge clk); #1;
      chk_all_quiet("mid_rst2");
      rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
         #1;
         chk_all_quiet("after_rst");
         @(posedge clk); #1;
      end
      rv = '{2'b10, 5, 0, 64'h300, 64'h0, 0, 0, -1, 0, 0, 5, 5};
      run_xfer(rv);
      chk("restart_nib", n_ib, 5);
      chk("restart_base", (acc_log.size() != 0) ? acc_log[0] : 64'hDEAD, 64'h300);

      // Randomized transfers
      for (int i = 0; i < 14; i++) begin
         rv.mode      = 2'($urandom);
         rv.height    = int'($urandom_range(6));
         rv.wgt       = int'($urandom_range(5));
         rv.dbase     = {$urandom, $urandom};
         rv.wbase     = {$urandom, $urandom};
         rv.wait_pct  = 30;
         rv.halt_pct  = 30;
         rv.wait_idx  = int'($urandom_range(3));
         rv.wait_len  = int'($urandom_range(3));
         rv.exp_nwb   = (rv.mode != 2'b10) ? rv.wgt : 0;
         rv.exp_nib   = (rv.mode != 2'b00) ? rv.height : 0;
         rv.exp_reads = -1;
         run_xfer(rv);
         chk("rnd_nwb", n_wb, rv.exp_nwb);
         chk("rnd_nib", n_ib, rv.exp_nib);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
